// File: rtl/az_bus_pkg.sv
// Shared definitions for the CPU bus arbiter: default sizing, master ids,
// active-low level constants and the arbiter state encoding.
package az_bus_pkg;

    localparam int DEF_NUM_MASTERS = 4;
    localparam int DEF_ID_W        = $clog2(DEF_NUM_MASTERS);

    typedef logic [DEF_ID_W-1:0] master_id_t;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam master_id_t M_IF  = master_id_t'(0);
    localparam master_id_t M_MEM = master_id_t'(1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/az_rr_pick.sv
// Combinational round-robin picker: first set bit of (req & ~excl) scanning
// upward from rr_ptr with wrap, done as a priority scan over a doubled vector.
module az_rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] rr_ptr,
    input  logic [N-1:0]    excl,
    output logic [ID_W-1:0] pick,
    output logic            pick_vld
);

    localparam int IDX_W = $clog2(2 * N);

    logic [N-1:0]     cand;
    logic [2*N-1:0]   dbl;
    logic [IDX_W-1:0] idx;

    assign cand = req & ~excl;
    assign dbl  = {cand, cand};

    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = '0;
        for (int i = 0; i < N; i++) begin
            idx = IDX_W'(rr_ptr) + IDX_W'(i);
            if (!pick_vld && dbl[idx]) begin
                pick_vld = 1'b1;
                // fold the doubled index back into 0..N-1 explicitly so non-power-of-2 N works
                pick     = (idx >= IDX_W'(N)) ? ID_W'(idx - IDX_W'(N)) : ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/az_bus_arbiter.sv
// Round-robin CPU bus arbiter: active-low requests in, registered one-cold
// grants out; ownership only changes on release or at a completed transfer.
module az_bus_arbiter
    import az_bus_pkg::*;
#(
    parameter  int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter  int MAX_HOLD    = 16,
    localparam int ID_W        = $clog2(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] m_reqn,
    output logic [NUM_MASTERS-1:0] m_grntn,
    input  logic                   bus_rdyn,
    output logic [ID_W-1:0]        owner_id,
    output logic                   owner_vld
);

    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    arb_state_e             state_q, state_d;
    logic [ID_W-1:0]        owner_q, owner_d;
    logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [NUM_MASTERS-1:0] req, excl, grntn_d;
    logic [ID_W-1:0]        pick;
    logic                   pick_vld;
    logic                   owner_req;
    logic                   hold_hit;

    function automatic logic [ID_W-1:0] inc_mod(input logic [ID_W-1:0] id);
        return (id == ID_W'(NUM_MASTERS - 1)) ? '0 : id + 1'b1;
    endfunction

    assign req       = ~m_reqn;
    assign owner_req = req[owner_q];
    assign hold_hit  = (MAX_HOLD > 0) && (hold_q >= HOLD_MAX);

    always_comb begin
        excl = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            excl[i] = (state_q == ST_OWNED) && (owner_q == ID_W'(i));
        end
    end

    az_rr_pick #(
        .N    (NUM_MASTERS),
        .ID_W (ID_W)
    ) u_pick (
        .req      (req),
        .rr_ptr   (rr_ptr_q),
        .excl     (excl),
        .pick     (pick),
        .pick_vld (pick_vld)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        hold_d   = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_d  = ST_OWNED;
                    owner_d  = pick;
                    rr_ptr_d = inc_mod(pick);
                    hold_d   = '0;
                end
            end
            ST_OWNED: begin
                // other masters' requests are only looked at when a handoff is possible
                if (!owner_req || (hold_hit && !bus_rdyn && pick_vld)) begin
                    if (pick_vld) begin
                        owner_d  = pick;
                        rr_ptr_d = inc_mod(pick);
                    end else begin
                        state_d = ST_IDLE;
                    end
                    hold_d = '0;
                end else if (hold_q < HOLD_MAX) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        grntn_d = {NUM_MASTERS{DISABLE_}};
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (state_d == ST_OWNED && owner_d == ID_W'(i)) grntn_d[i] = ENABLE_;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            owner_q  <= ID_W'(M_IF);
            rr_ptr_q <= '0;
            hold_q   <= '0;
            m_grntn  <= {NUM_MASTERS{DISABLE_}};
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            hold_q   <= hold_d;
            m_grntn  <= grntn_d;
        end
    end

    assign owner_vld = (state_q == ST_OWNED);
    assign owner_id  = owner_q;

endmodule

// File: tb/tb_az_bus_arbiter.sv
// Directed scoreboard bench for az_bus_arbiter (4 masters, MAX_HOLD=4).
module tb_az_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] m_reqn;
    logic [3:0] m_grntn;
    logic       bus_rdyn;
    logic [1:0] owner_id;
    logic       owner_vld;

    az_bus_arbiter #(
        .NUM_MASTERS (4),
        .MAX_HOLD    (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .m_reqn    (m_reqn),
        .m_grntn   (m_grntn),
        .bus_rdyn  (bus_rdyn),
        .owner_id  (owner_id),
        .owner_vld (owner_vld)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    int         exp_due[$];
    logic [3:0] exp_g[$];
    logic       exp_v[$];
    int         exp_id[$];
    string      exp_nm[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input logic r, input logic [3:0] rq, input logic rdy,
                        input logic [3:0] eg, input logic ev, input int eid, input string nm);
        reset    = r;
        m_reqn   = rq;
        bus_rdyn = rdy;
        exp_due.push_back(cyc + 1);
        exp_g.push_back(eg);
        exp_v.push_back(ev);
        exp_id.push_back(eid);
        exp_nm.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // Monitor: invariants every cycle, plus scoreboard entries due this cycle.
    initial begin
        logic [3:0] g, inv_exp;
        string      nm;
        forever begin
            @(posedge clk);
            #2;
            if (cyc >= 1) begin
                chk("inv_onecold", int'($countones(~m_grntn) <= 1), 1);
                inv_exp = owner_vld ? ~(4'b0001 << owner_id) : 4'b1111;
                chk("inv_owner_grant", int'(m_grntn), int'(inv_exp));
            end
            while (exp_due.size() > 0 && exp_due[0] <= cyc) begin
                void'(exp_due.pop_front());
                g  = exp_g.pop_front();
                nm = exp_nm.pop_front();
                chk({nm, "_grntn"}, int'(m_grntn), int'(g));
                chk({nm, "_vld"}, int'(owner_vld), int'(exp_v.pop_front()));
                chk({nm, "_id"}, int'(owner_id), exp_id.pop_front());
            end
        end
    end

    initial begin
        reset    = 1'b1;
        m_reqn   = 4'b1111;
        bus_rdyn = 1'b1;

        // reset with everyone requesting, then first grant goes to master 0
        step(1, 4'b0000, 1, 4'b1111, 0, 0, "rst_a");
        step(1, 4'b0000, 1, 4'b1111, 0, 0, "rst_b");
        step(0, 4'b0000, 1, 4'b1110, 1, 0, "rst_g0");
        step(0, 4'b1111, 1, 4'b1111, 0, 0, "idle0");

        // lone request from master 1
        step(0, 4'b1101, 1, 4'b1101, 1, 1, "lone_g1");
        step(0, 4'b1111, 1, 4'b1111, 0, 1, "lone_rel");

        // all requesting, owner releases after one cycle: 0,1,2,3,0 back to back
        step(1, 4'b1111, 1, 4'b1111, 0, 0, "rst_c");
        step(0, 4'b0000, 1, 4'b1110, 1, 0, "rr_0");
        step(0, 4'b0001, 1, 4'b1101, 1, 1, "rr_1");
        step(0, 4'b0010, 1, 4'b1011, 1, 2, "rr_2");
        step(0, 4'b0100, 1, 4'b0111, 1, 3, "rr_3");
        step(0, 4'b1000, 1, 4'b1110, 1, 0, "rr_0b");
        step(0, 4'b1111, 1, 4'b1111, 0, 0, "rr_idle");

        // hold limit: master 0 owns, master 2 waits, ready low every other cycle
        step(0, 4'b1110, 1, 4'b1110, 1, 0, "hold_g0");
        step(0, 4'b1010, 1, 4'b1110, 1, 0, "hold_c1");
        step(0, 4'b1010, 0, 4'b1110, 1, 0, "hold_c2");
        step(0, 4'b1010, 1, 4'b1110, 1, 0, "hold_c3");
        step(0, 4'b1010, 0, 4'b1110, 1, 0, "hold_c4");
        step(0, 4'b1010, 1, 4'b1110, 1, 0, "hold_c5");
        step(0, 4'b1010, 0, 4'b1011, 1, 2, "hold_rot2");
        step(0, 4'b1110, 1, 4'b1110, 1, 0, "hold_back0");
        step(0, 4'b1111, 1, 4'b1111, 0, 0, "hold_idle");

        // ready never low: owner is never rotated out
        step(0, 4'b1110, 1, 4'b1110, 1, 0, "stk_g0");
        for (int i = 0; i < 10; i++) step(0, 4'b1010, 1, 4'b1110, 1, 0, "stk_hold");
        step(0, 4'b1011, 1, 4'b1011, 1, 2, "stk_rel");
        step(0, 4'b1111, 1, 4'b1111, 0, 2, "stk_idle");

        // reset while master 3 owns mid-transfer; pointer restarts at 0
        step(0, 4'b0111, 0, 4'b0111, 1, 3, "mid_g3");
        step(0, 4'b0111, 1, 4'b0111, 1, 3, "mid_hold");
        step(1, 4'b0111, 1, 4'b1111, 0, 0, "mid_rst");
        step(0, 4'b0110, 1, 4'b1110, 1, 0, "mid_restart");
        step(0, 4'b1101, 1, 4'b1101, 1, 1, "mid_h1");
        step(1, 4'b1001, 1, 4'b1111, 0, 0, "rst_ptr");
        step(0, 4'b1001, 1, 4'b1101, 1, 1, "ptr_after_rst");
        step(0, 4'b1111, 1, 4'b1111, 0, 1, "end_idle");

        repeat (2) @(posedge clk);
        #3;
        checks++;
        if (exp_due.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_due.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
